// File: rtl/mux_2x1.sv
// Registered 2:1 multiplexer with capture enable, valid flag and select-change tracking.
// Every output is a flop; nothing combinational reaches the ports.
module mux_2x1 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_q,
    output logic             sel_toggle,
    output logic [CNT_W-1:0] toggle_count
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sel_reg_q, sel_reg_d;
    logic             toggle_q, toggle_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        sel_reg_d = sel_reg_q;
        toggle_d  = 1'b0;
        count_d   = count_q;
        if (en) begin
            data_d    = sel ? in1 : in0;
            valid_d   = 1'b1;
            sel_reg_d = sel;
            // The first capture after reset has no previous select to compare against.
            toggle_d  = valid_q && (sel != sel_reg_q);
            if (toggle_d && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            sel_reg_q <= 1'b0;
            toggle_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sel_reg_q <= sel_reg_d;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
        end
    end

    assign out          = data_q;
    assign out_valid    = valid_q;
    assign sel_q        = sel_reg_q;
    assign sel_toggle   = toggle_q;
    assign toggle_count = count_q;

endmodule

// File: tb/tb_mux_2x1.sv
// Table-driven bench for mux_2x1: a 1-bit/8-bit-counter instance and a 4-bit/2-bit-counter
// instance share control inputs; expected records go through a scoreboard queue.
module tb_mux_2x1;

    logic       clk = 1'b0;
    logic       rst, en, sel;
    logic       in0, in1;
    logic [3:0] in0w, in1w;

    logic       out, out_valid, sel_q, sel_toggle;
    logic [7:0] toggle_count;
    logic [3:0] outw;
    logic       out_valid_w, sel_q_w, sel_toggle_w;
    logic [1:0] toggle_count_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_2x1 #(.WIDTH(1), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in0          (in0),
        .in1          (in1),
        .sel          (sel),
        .en           (en),
        .out          (out),
        .out_valid    (out_valid),
        .sel_q        (sel_q),
        .sel_toggle   (sel_toggle),
        .toggle_count (toggle_count)
    );

    mux_2x1 #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .in0          (in0w),
        .in1          (in1w),
        .sel          (sel),
        .en           (en),
        .out          (outw),
        .out_valid    (out_valid_w),
        .sel_q        (sel_q_w),
        .sel_toggle   (sel_toggle_w),
        .toggle_count (toggle_count_w)
    );

    typedef struct {
        logic       rst, en, sel, in0, in1;
        logic       out, valid, selq, tog;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic       sat;
        logic [3:0] out;
        logic       valid, selq, tog;
        logic [7:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_next(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 (step %0d)", idx);
            return;
        end
        e = sb.pop_front();
        if (!e.sat) begin
            check($sformatf("out[%0d]", idx),        32'(out),          32'(e.out[0]));
            check($sformatf("valid[%0d]", idx),      32'(out_valid),    32'(e.valid));
            check($sformatf("sel_q[%0d]", idx),      32'(sel_q),        32'(e.selq));
            check($sformatf("sel_toggle[%0d]", idx), 32'(sel_toggle),   32'(e.tog));
            check($sformatf("count[%0d]", idx),      32'(toggle_count), 32'(e.cnt));
        end else begin
            check($sformatf("sat_out[%0d]", idx),    32'(outw),           32'(e.out));
            check($sformatf("sat_valid[%0d]", idx),  32'(out_valid_w),    32'(e.valid));
            check($sformatf("sat_sel_q[%0d]", idx),  32'(sel_q_w),        32'(e.selq));
            check($sformatf("sat_toggle[%0d]", idx), 32'(sel_toggle_w),   32'(e.tog));
            check($sformatf("sat_count[%0d]", idx),  32'(toggle_count_w), 32'(e.cnt));
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic e, input logic s, input logic i0,
                         input logic i1, input logic [3:0] w0, input logic [3:0] w1);
        @(negedge clk);
        rst  = r;
        en   = e;
        sel  = s;
        in0  = i0;
        in1  = i1;
        in0w = w0;
        in1w = w1;
    endtask

    initial begin
        // rst en sel in0 in1 | out valid sel_q tog cnt
        tbl.push_back('{1, 1, 1, 0, 1,  0, 0, 0, 0, 8'd0});  // reset with capture pending
        tbl.push_back('{0, 1, 0, 0, 1,  0, 1, 0, 0, 8'd0});  // first capture: no toggle
        tbl.push_back('{0, 1, 1, 0, 1,  1, 1, 1, 1, 8'd1});
        tbl.push_back('{0, 1, 0, 1, 0,  1, 1, 0, 1, 8'd2});
        tbl.push_back('{0, 1, 1, 1, 0,  0, 1, 1, 1, 8'd3});
        tbl.push_back('{0, 1, 1, 1, 1,  1, 1, 1, 0, 8'd3});  // same sel: no pulse
        tbl.push_back('{0, 0, 0, 0, 0,  1, 1, 1, 0, 8'd3});  // hold for 5 cycles
        tbl.push_back('{0, 0, 1, 1, 0,  1, 1, 1, 0, 8'd3});
        tbl.push_back('{0, 0, 0, 0, 1,  1, 1, 1, 0, 8'd3});
        tbl.push_back('{0, 0, 1, 0, 0,  1, 1, 1, 0, 8'd3});
        tbl.push_back('{0, 0, 0, 1, 1,  1, 1, 1, 0, 8'd3});
        tbl.push_back('{1, 1, 1, 0, 1,  0, 0, 0, 0, 8'd0});  // reset beats enable
        tbl.push_back('{0, 0, 1, 0, 1,  0, 0, 0, 0, 8'd0});  // deassert alone changes nothing
        tbl.push_back('{0, 1, 1, 0, 1,  1, 1, 1, 0, 8'd0});  // first capture, sel=1, no toggle
        tbl.push_back('{0, 1, 0, 0, 0,  0, 1, 0, 1, 8'd1});  // sel and data change together
        tbl.push_back('{0, 1, 1, 1, 1,  1, 1, 1, 1, 8'd2});
        tbl.push_back('{0, 1, 0, 0, 0,  0, 1, 0, 1, 8'd3});  // unselected in1 toggles below
        tbl.push_back('{0, 1, 0, 0, 1,  0, 1, 0, 0, 8'd3});
        tbl.push_back('{0, 1, 0, 0, 0,  0, 1, 0, 0, 8'd3});
        tbl.push_back('{0, 1, 0, 0, 1,  0, 1, 0, 0, 8'd3});
        tbl.push_back('{0, 1, 0, 0, 0,  0, 1, 0, 0, 8'd3});
        tbl.push_back('{1, 1, 0, 1, 0,  0, 0, 0, 0, 8'd0});  // reset discards capture

        rst = 1'b1; en = 1'b0; sel = 1'b0;
        in0 = 1'b0; in1 = 1'b0; in0w = 4'h0; in1w = 4'h0;

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            drive(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].in0, tbl[i].in1, 4'h0, 4'h0);
            e.sat   = 1'b0;
            e.out   = {3'b000, tbl[i].out};
            e.valid = tbl[i].valid;
            e.selq  = tbl[i].selq;
            e.tog   = tbl[i].tog;
            e.cnt   = tbl[i].cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            compare_next(i);
        end

        // Saturation on the 2-bit counter: sel flips on every enabled edge.
        begin
            logic [1:0] exp_cnt [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
            logic [3:0] w0, w1;
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            @(posedge clk);
            #1;
            check("sat_reset_count", 32'(toggle_count_w), 32'd0);
            check("sat_reset_out",   32'(outw),           32'd0);
            for (int k = 0; k < 7; k++) begin
                exp_t e;
                logic s;
                s  = k[0];
                w0 = 4'(4'hA + k);
                w1 = 4'(4'h5 - k);
                drive(1'b0, 1'b1, s, 1'b0, 1'b0, w0, w1);
                e.sat   = 1'b1;
                e.out   = s ? w1 : w0;
                e.valid = 1'b1;
                e.selq  = s;
                e.tog   = (k != 0);
                e.cnt   = {6'b0, exp_cnt[k]};
                sb.push_back(e);
                @(posedge clk);
                #1;
                compare_next(100 + k);
            end
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
